load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response bus between a requester and the load/store unit.
//   master : drives req_valid/req_write/req_size/req_signed/req_addr/req_wdata,
//            observes req_ready and resp_valid/resp_rdata/resp_exc.
//   slave  : the load/store unit side of the same signals.
// req_size: 00 word, 01 half, 10 byte, 11 double.
// resp_exc: 00 none, 01 out-of-bounds store, 10 out-of-bounds read, 11 misaligned.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic [1:0]  resp_exc;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_exc
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_exc
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, checks it locally against the
// data memory bounds, drives the data memory for MEM_LATENCY wait cycles and
// returns a one-cycle response with extended load data and a status code.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   bus (slave)      request handshake and response (see load_store_unit_if)
//   memWrite/memRead data memory strobes
//   sizeSelect       access size to the memory, same encoding as req_size
//   address          byte address to the memory
//   writeData        store data to the memory, LSB-aligned
//   readData         memory read data, LSB-aligned
//   dataMemoryExc    memory status, captured with readData
//   exc_count        saturating count of completions with a non-zero status
//
// Optional feature: define LSU_ALIGN_CHECK_EN to fault misaligned accesses with
// status 11 (takes priority over the bounds check).
module load_store_unit #(
  parameter int unsigned NUM_DATA    = 20,
  parameter int unsigned MEM_LATENCY = 1   // 1..15
) (
  input  logic                     clk,
  input  logic                     rst,
  load_store_unit_if.slave         bus,
  output logic                     memWrite,
  output logic                     memRead,
  output logic [1:0]               sizeSelect,
  output logic [63:0]              address,
  output logic [63:0]              writeData,
  input  logic [63:0]              readData,
  input  logic [1:0]               dataMemoryExc,
  output logic [7:0]               exc_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [1:0] ExcNone     = 2'b00;
  localparam logic [1:0] ExcStoreOob = 2'b01;
  localparam logic [1:0] ExcLoadOob  = 2'b10;
  localparam logic [1:0] ExcMisalign = 2'b11;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic        signed_q;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] n;
    unique case (size)
      2'b00:   n = 4'd4;
      2'b01:   n = 4'd2;
      2'b10:   n = 4'd1;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] size,
                                         input logic sgn);
    logic [63:0] r;
    unique case (size)
      2'b00:   r = sgn ? {{32{d[31]}}, d[31:0]} : {32'd0, d[31:0]};
      2'b01:   r = sgn ? {{48{d[15]}}, d[15:0]} : {48'd0, d[15:0]};
      2'b10:   r = sgn ? {{56{d[7]}}, d[7:0]}   : {56'd0, d[7:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Acceptance-time checks on the raw request; 65-bit end address so a request
  // that wraps past 2^64 is caught as out of bounds.
  logic [3:0]  req_bytes;
  logic [64:0] req_end;
  logic        oob;
  logic        misalign;
  logic [1:0]  local_code;

  assign req_bytes = size_bytes(bus.req_size);
  assign req_end   = {1'b0, bus.req_addr} + {61'd0, req_bytes};
  assign oob       = req_end > 65'(NUM_DATA);

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = (bus.req_addr[3:0] & (req_bytes - 4'd1)) != 4'd0;
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    local_code = ExcNone;
    if (misalign) begin
      local_code = ExcMisalign;
    end else if (oob) begin
      local_code = bus.req_write ? ExcStoreOob : ExcLoadOob;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= 4'd0;
      write_q        <= 1'b0;
      signed_q       <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 64'd0;
      bus.resp_exc   <= ExcNone;
      memWrite       <= 1'b0;
      memRead        <= 1'b0;
      sizeSelect     <= 2'b00;
      address        <= 64'd0;
      writeData      <= 64'd0;
      exc_count      <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid && bus.req_ready) begin
            write_q       <= bus.req_write;
            signed_q      <= bus.req_signed;
            bus.req_ready <= 1'b0;
            if (local_code != ExcNone) begin
              // Faulted locally: the memory is never touched.
              state_q        <= StResp;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= 64'd0;
              bus.resp_exc   <= local_code;
            end else begin
              state_q    <= StIssue;
              address    <= bus.req_addr;
              sizeSelect <= bus.req_size;
              writeData  <= bus.req_wdata;
              memWrite   <= bus.req_write;
              memRead    <= ~bus.req_write;
            end
          end
        end
        StIssue: begin
          state_q  <= StWait;
          memWrite <= 1'b0;
          cnt_q    <= 4'(MEM_LATENCY - 1);
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q        <= StResp;
            memRead        <= 1'b0;
            address        <= 64'd0;
            sizeSelect     <= 2'b00;
            writeData      <= 64'd0;
            bus.resp_valid <= 1'b1;
            bus.resp_exc   <= dataMemoryExc;
            bus.resp_rdata <= write_q ? 64'd0 : extend(readData, sizeSelect, signed_q);
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q        <= StIdle;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
          bus.resp_rdata <= 64'd0;
          bus.resp_exc   <= ExcNone;
          if (bus.resp_exc != ExcNone && exc_count != 8'hFF) begin
            exc_count <= exc_count + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-array memory model.
module tb_load_store_unit;
  localparam int unsigned NUM_DATA    = 20;
  localparam int unsigned MEM_LATENCY = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memWrite, memRead;
  logic [1:0]  sizeSelect;
  logic [63:0] address, writeData;
  logic [63:0] readData;
  logic [1:0]  mem_exc = 2'b00;
  logic [7:0]  exc_count;

  logic [7:0]  mem [NUM_DATA] = '{default: 8'h00};

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  load_store_unit_if bus ();

  load_store_unit #(
    .NUM_DATA    (NUM_DATA),
    .MEM_LATENCY (MEM_LATENCY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .memWrite      (memWrite),
    .memRead       (memRead),
    .sizeSelect    (sizeSelect),
    .address       (address),
    .writeData     (writeData),
    .readData      (readData),
    .dataMemoryExc (mem_exc),
    .exc_count     (exc_count)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'b00:   return 4;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 8;
    endcase
  endfunction

  always @(posedge clk) begin
    if (memWrite) begin
      for (int i = 0; i < 8; i++) begin
        int idx;
        idx = int'(address[15:0]) + i;
        if (i < nbytes(sizeSelect) && idx < int'(NUM_DATA)) mem[idx] <= writeData[8*i +: 8];
      end
    end
  end

  always_comb begin
    readData = 64'd0;
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = int'(address[15:0]) + i;
      if (i < nbytes(sizeSelect) && idx < int'(NUM_DATA)) readData[8*i +: 8] = mem[idx];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transaction with all timing/strobe expectations derived from
  // whether the request should fault locally.
  task automatic xact(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [63:0] ad, input logic [63:0] wd,
                      input logic [63:0] exp_rd, input logic [1:0] exp_exc,
                      input bit local_fault);
    int lat = 0, rd_cyc = 0, wr_cyc = 0, busy_rdy = 0, bad_bus = 0;
    bit done = 0;
    logic [63:0] got_rd = '0;
    logic [1:0]  got_exc = '0;
    @(negedge clk);
    check_eq({tag, ":ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = ad;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (memRead) rd_cyc++;
      if (memWrite) wr_cyc++;
      if (bus.req_ready) busy_rdy++;
      if ((memRead || memWrite) && (address !== ad || sizeSelect !== sz)) bad_bus++;
      if (bus.resp_valid) begin
        done    = 1;
        got_rd  = bus.resp_rdata;
        got_exc = bus.resp_exc;
      end
    end
    check_eq({tag, ":done"}, 64'(done), 64'd1);
    check_eq({tag, ":lat"}, 64'(lat), local_fault ? 64'd1 : 64'(2 + MEM_LATENCY));
    check_eq({tag, ":rdata"}, got_rd, exp_rd);
    check_eq({tag, ":exc"}, 64'(got_exc), 64'(exp_exc));
    check_eq({tag, ":rd_cyc"}, 64'(rd_cyc), (!wr && !local_fault) ? 64'(1 + MEM_LATENCY) : 64'd0);
    check_eq({tag, ":wr_cyc"}, 64'(wr_cyc), (wr && !local_fault) ? 64'd1 : 64'd0);
    check_eq({tag, ":busy_ready"}, 64'(busy_rdy), 64'd0);
    check_eq({tag, ":bus_stable"}, 64'(bad_bus), 64'd0);
    if (exp_exc != 2'b00 && exp_cnt < 255) exp_cnt++;
    @(negedge clk);
    check_eq({tag, ":resp_drop"}, 64'(bus.resp_valid), 64'd0);
    check_eq({tag, ":rdata_zero"}, bus.resp_rdata, 64'd0);
    check_eq({tag, ":exc_count"}, 64'(exc_count), 64'(exp_cnt));
  endtask

  initial begin
    int gap_resp;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 64'd0;
    bus.req_wdata  = 64'd0;

    repeat (2) @(negedge clk);
    check_eq("rst:ready", 64'(bus.req_ready), 64'd1);
    check_eq("rst:resp_valid", 64'(bus.resp_valid), 64'd0);
    check_eq("rst:mem_strobes", {62'd0, memRead, memWrite}, 64'd0);
    check_eq("rst:address", address, 64'd0);
    check_eq("rst:exc_count", 64'(exc_count), 64'd0);
    rst = 1'b0;

    // Store/load double round trip.
    xact("st_d8", 1'b1, 2'b11, 1'b0, 64'd8, 64'h1122334455667788, 64'd0, 2'b00, 0);
    xact("ld_d8", 1'b0, 2'b11, 1'b0, 64'd8, 64'd0, 64'h1122334455667788, 2'b00, 0);

    // Byte 0x80 at addr 3, signed and unsigned reads; neighbour untouched.
    xact("st_b3", 1'b1, 2'b10, 1'b0, 64'd3, 64'hAB80, 64'd0, 2'b00, 0);
    xact("ld_bs3", 1'b0, 2'b10, 1'b1, 64'd3, 64'd0, 64'hFFFFFFFFFFFFFF80, 2'b00, 0);
    xact("ld_bu3", 1'b0, 2'b10, 1'b0, 64'd3, 64'd0, 64'h80, 2'b00, 0);
    xact("ld_bu4", 1'b0, 2'b10, 1'b0, 64'd4, 64'd0, 64'h0, 2'b00, 0);

    // Bounds: word at 18 and 17 fault, word at 16 fits exactly.
    xact("ld_w18", 1'b0, 2'b00, 1'b0, 64'd18, 64'd0, 64'd0, 2'b10, 1);
    xact("st_w17", 1'b1, 2'b00, 1'b0, 64'd17, 64'hDEAD, 64'd0, 2'b01, 1);
    xact("st_w16", 1'b1, 2'b00, 1'b0, 64'd16, 64'hFFFF_FFFF_CAFE_BABE, 64'd0, 2'b00, 0);
    xact("ld_ws16", 1'b0, 2'b00, 1'b1, 64'd16, 64'd0, 64'hFFFFFFFFCAFEBABE, 2'b00, 0);
    xact("ld_wu16", 1'b0, 2'b00, 1'b0, 64'd16, 64'd0, 64'hCAFEBABE, 2'b00, 0);
    xact("ld_hs16", 1'b0, 2'b01, 1'b1, 64'd16, 64'd0, 64'hFFFFFFFFFFFFBABE, 2'b00, 0);
    xact("ld_hu18", 1'b0, 2'b01, 1'b0, 64'd18, 64'd0, 64'hCAFE, 2'b00, 0);

    // Misaligned half at addr 1.
`ifdef LSU_ALIGN_CHECK_EN
    xact("st_h1", 1'b1, 2'b01, 1'b0, 64'd1, 64'h5566, 64'd0, 2'b11, 1);
    xact("ld_h1", 1'b0, 2'b01, 1'b0, 64'd1, 64'd0, 64'd0, 2'b11, 1);
`else
    xact("st_h1", 1'b1, 2'b01, 1'b0, 64'd1, 64'h5566, 64'd0, 2'b00, 0);
    xact("ld_h1", 1'b0, 2'b01, 1'b0, 64'd1, 64'd0, 64'h5566, 2'b00, 0);
    xact("ld_w0", 1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 64'h80556600, 2'b00, 0);
`endif

    // Address wrap near 2^64.
    xact("ld_bwrap", 1'b0, 2'b10, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 64'd0, 2'b10, 1);
    xact("st_dwrap", 1'b1, 2'b11, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd1, 64'd0, 2'b01, 1);

    // Memory-reported status is passed through with the load data.
    mem_exc = 2'b01;
    xact("ld_memexc", 1'b0, 2'b10, 1'b0, 64'd3, 64'd0, 64'h80, 2'b01, 0);
    mem_exc = 2'b00;

    // Saturation of the fault counter.
    for (int i = 0; i < 250; i++) begin
      xact("sat", 1'b0, 2'b11, 1'b0, 64'd16, 64'd0, 64'd0, 2'b10, 1);
    end
    check_eq("sat:final", 64'(exc_count), 64'd255);

    // Reset in the WAIT cycle of a load.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b11;
    bus.req_signed = 1'b0;
    bus.req_addr   = 64'd8;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);  // ISSUE
    @(negedge clk);  // WAIT
    check_eq("rstw:in_wait", 64'(memRead), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("rstw:memRead", 64'(memRead), 64'd0);
    check_eq("rstw:ready", 64'(bus.req_ready), 64'd1);
    check_eq("rstw:resp_valid", 64'(bus.resp_valid), 64'd0);
    check_eq("rstw:address", address, 64'd0);
    check_eq("rstw:exc_count", 64'(exc_count), 64'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    gap_resp = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.resp_valid) gap_resp++;
    end
    check_eq("rstw:no_resp", 64'(gap_resp), 64'd0);
    xact("st_after_rst", 1'b1, 2'b10, 1'b0, 64'd5, 64'h5A, 64'd0, 2'b00, 0);
    xact("ld_after_rst", 1'b0, 2'b10, 1'b0, 64'd5, 64'd0, 64'h5A, 2'b00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
